// File: rtl/scsp_eg_pkg.sv
// scsp_eg_pkg: shared types, constants and envelope helper functions for the SCSP EG stage
// Exports: EGState_t, OPPipe_t, SCR1_t, SCR2_t, SCR5_t, OP4State_t, RateCalc, EgStep, EgLevel
package scsp_eg_pkg;
    localparam int SLOT_W = 5;
    localparam logic [9:0] EVOL_MAX = 10'h3FF;
    localparam logic [5:0] EG_FAST_RATE = 6'h30;
    typedef enum logic [1:0] {EGS_ATTACK, EGS_DECAY1, EGS_DECAY2, EGS_RELEASE} EGState_t;
    typedef struct packed {
        logic [SLOT_W-1:0] SLOT;
        logic              KON;
        logic              KOFF;
    } OPPipe_t;
    localparam OPPipe_t OP_PIPE_RESET = '0;
    typedef struct packed {
        logic [3:0] KRS;
        logic [4:0] DL;
        logic [4:0] RR;
        logic       LPSLNK;
    } SCR1_t;
    typedef struct packed {
        logic [4:0] AR;
        logic [4:0] D1R;
        logic [4:0] D2R;
        logic       EGHOLD;
    } SCR2_t;
    typedef struct packed {
        logic [3:0] OCT;
        logic [9:0] FNS;
    } SCR5_t;
    typedef struct packed {
        logic [9:0] EVOL;
        EGState_t   ST;
    } OP4State_t;

    // Key-rate scaling: KRS=0xF disables it; OCT is signed, FNS[9] adds the half step.
    function automatic logic [5:0] RateCalc(input logic [4:0] r, input logic [3:0] krs, input SCR5_t scr5);
        int ks;
        int sum;
        ks = (krs == 4'hF) ? 0 : 2 * (int'(krs) + int'($signed(scr5.OCT))) + int'(scr5.FNS[9]);
        sum = 2 * int'(r) + ks;
        return (r == 5'd0 || sum <= 0) ? 6'd0 : (sum >= 60) ? 6'h3C : 6'(sum);
    endfunction

    // Returns {step_en, INC}; fast rates step every sample with INC capped at 8.
    function automatic logic [4:0] EgStep(input logic [5:0] rate, input logic [31:0] smp);
        logic [3:0] q;
        logic [31:0] mask;
        q = rate[5:2];
        mask = (32'd1 << (4'd11 - q)) - 32'd1;
        if (rate == 6'd0) return 5'd0;
        if (rate < EG_FAST_RATE) return {(smp & mask) == 32'd0, 4'd1};
        return {1'b1, (q == 4'hF) ? 4'd8 : 4'd1 << (q - 4'd11)};
    endfunction

    function automatic logic [9:0] EgLevel(input logic [9:0] evol, input logic [7:0] tl, input logic eghold, input EGState_t st);
        logic [10:0] sum;
        sum = {1'b0, (eghold && st == EGS_ATTACK) ? 10'd0 : evol} + {1'b0, tl, 2'b00};
        return sum[10] ? EVOL_MAX : sum[9:0];
    endfunction
endpackage

// File: rtl/scsp_eg_if.sv
// scsp_eg_if: slot-pipeline bus into and out of the envelope stage
// master drives CE/PIPE_IN/SCR1/SCR2/SCR5/TL/LOOP_HIT and reads PIPE_OUT/EG_OUT/LEVEL/VALID; slave is the EG
interface scsp_eg_if;
    import scsp_eg_pkg::*;
    logic       CE;
    OPPipe_t    PIPE_IN;
    SCR1_t      SCR1;
    SCR2_t      SCR2;
    SCR5_t      SCR5;
    logic [7:0] TL;
    logic       LOOP_HIT;
    OPPipe_t    PIPE_OUT;
    OP4State_t  EG_OUT;
    logic [9:0] LEVEL;
    logic       VALID;
    modport master (output CE, PIPE_IN, SCR1, SCR2, SCR5, TL, LOOP_HIT, input PIPE_OUT, EG_OUT, LEVEL, VALID);
    modport slave (input CE, PIPE_IN, SCR1, SCR2, SCR5, TL, LOOP_HIT, output PIPE_OUT, EG_OUT, LEVEL, VALID);
endinterface

// File: rtl/scsp_eg_rate.sv
// scsp_eg_rate: picks the rate for the slot's EG state, scales it and decides step/INC
// Ports: st, ar/d1r/d2r/rr, krs, scr5, smp in; step_en, inc out (combinational)
module scsp_eg_rate
    import scsp_eg_pkg::*;
(
    input  EGState_t    st,
    input  logic [4:0]  ar,
    input  logic [4:0]  d1r,
    input  logic [4:0]  d2r,
    input  logic [4:0]  rr,
    input  logic [3:0]  krs,
    input  SCR5_t       scr5,
    input  logic [31:0] smp,
    output logic        step_en,
    output logic [3:0]  inc
);
    logic [4:0] r;
    logic [5:0] rate;
    always_comb begin
        r = (st == EGS_ATTACK) ? ar : (st == EGS_DECAY1) ? d1r : (st == EGS_DECAY2) ? d2r : rr;
        rate = RateCalc(r, krs, scr5);
        {step_en, inc} = EgStep(rate, smp);
    end
endmodule

// File: rtl/scsp_eg.sv
// scsp_eg: time-multiplexed SCSP envelope generator, one slot advanced per CE
// Ports: CLK, RST_N (async active-low), bus (scsp_eg_if.slave: slot inputs in, PIPE_OUT/EG_OUT/LEVEL/VALID out)
module scsp_eg
    import scsp_eg_pkg::*;
#(
    parameter int SLOTS = 32,
    parameter int CNT_W = 15
) (
    input logic      CLK,
    input logic      RST_N,
    scsp_eg_if.slave bus
);
    localparam int IDX_W = $clog2(SLOTS);
    logic [9:0] evol_q [SLOTS];
    EGState_t st_q [SLOTS];
    logic [CNT_W-1:0] smp_q, smp_d;
    OPPipe_t pipe_out_q, pipe_out_d;
    OP4State_t eg_out_q, eg_out_d;
    logic [9:0] level_q, level_d;
    logic valid_q, valid_d;
    logic [IDX_W-1:0] idx;
    logic [9:0] cur_evol, att_sub, att_evol, up_evol, step_evol, evol_d;
    logic [10:0] up_sum;
    EGState_t cur_st, st_d;
    logic step_en, kon, koff, loop_end;
    logic [3:0] inc;

    scsp_eg_rate u_rate (
        .st(cur_st),
        .ar(bus.SCR2.AR),
        .d1r(bus.SCR2.D1R),
        .d2r(bus.SCR2.D2R),
        .rr(bus.SCR1.RR),
        .krs(bus.SCR1.KRS),
        .scr5(bus.SCR5),
        .smp(32'(smp_q)),
        .step_en(step_en),
        .inc(inc)
    );

    always_comb begin
        idx = bus.PIPE_IN.SLOT[IDX_W-1:0];
        cur_evol = evol_q[idx];
        cur_st = st_q[idx];
        kon = bus.PIPE_IN.KON;
        koff = bus.PIPE_IN.KOFF;
        loop_end = cur_st == EGS_ATTACK && bus.SCR1.LPSLNK && bus.LOOP_HIT;
        att_sub = (cur_evol >> 4) + 10'(inc);
        att_evol = (att_sub >= cur_evol) ? 10'd0 : cur_evol - att_sub;
        up_sum = {1'b0, cur_evol} + 11'(inc);
        up_evol = up_sum[10] ? EVOL_MAX : up_sum[9:0];
        step_evol = !step_en ? cur_evol : (cur_st == EGS_ATTACK) ? att_evol : up_evol;
        evol_d = kon ? ((bus.SCR2.AR == 5'h1F) ? 10'd0 : EVOL_MAX) : (koff || loop_end) ? cur_evol : step_evol;
        // Key events take priority; otherwise the DL compare uses the post-step level.
        st_d = kon ? ((bus.SCR2.AR == 5'h1F) ? EGS_DECAY1 : EGS_ATTACK) :
               koff ? EGS_RELEASE :
               loop_end ? EGS_DECAY1 :
               (cur_st == EGS_ATTACK && step_evol == 10'd0) ? EGS_DECAY1 :
               (cur_st == EGS_DECAY1 && step_evol[9:5] >= bus.SCR1.DL) ? EGS_DECAY2 : cur_st;
        smp_d = (bus.CE && bus.PIPE_IN.SLOT == SLOT_W'(SLOTS - 1)) ? smp_q + CNT_W'(1) : smp_q;
        pipe_out_d = bus.CE ? bus.PIPE_IN : pipe_out_q;
        eg_out_d = bus.CE ? OP4State_t'{EVOL: evol_d, ST: st_d} : eg_out_q;
        level_d = bus.CE ? EgLevel(evol_d, bus.TL, bus.SCR2.EGHOLD, st_d) : level_q;
        valid_d = valid_q | bus.CE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < SLOTS; i++) begin
                evol_q[i] <= EVOL_MAX;
                st_q[i] <= EGS_RELEASE;
            end
            smp_q <= '0;
            pipe_out_q <= OP_PIPE_RESET;
            eg_out_q <= OP4State_t'{EVOL: EVOL_MAX, ST: EGS_RELEASE};
            level_q <= EVOL_MAX;
            valid_q <= 1'b0;
        end else begin
            if (bus.CE) begin
                evol_q[idx] <= evol_d;
                st_q[idx] <= st_d;
            end
            smp_q <= smp_d;
            pipe_out_q <= pipe_out_d;
            eg_out_q <= eg_out_d;
            level_q <= level_d;
            valid_q <= valid_d;
        end
    end

    assign bus.PIPE_OUT = pipe_out_q;
    assign bus.EG_OUT = eg_out_q;
    assign bus.LEVEL = level_q;
    assign bus.VALID = valid_q;
endmodule

// File: tb/tb_scsp_eg.sv
// tb_scsp_eg: randomized slot traffic with directed slots, checked against a per-slot envelope model
module tb_scsp_eg;
    import scsp_eg_pkg::*;
    localparam int ST_ATT = int'(EGS_ATTACK);
    localparam int ST_D1 = int'(EGS_DECAY1);
    localparam int ST_D2 = int'(EGS_DECAY2);
    localparam int ST_REL = int'(EGS_RELEASE);
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;
    scsp_eg_if bus();
    scsp_eg #(.SLOTS(32), .CNT_W(15)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus.slave));

    int checks = 0;
    int errors = 0;
    int ar[32], d1r[32], d2r[32], rr[32], dl[32], krs[32], oct[32], fns[32], tl[32];
    bit eghold[32], lps[32];
    int m_evol[32], m_st[32], m_smp;
    int e_evol, e_st, e_level, e_valid, e_pipe, e_s, e_slot;
    bit e_fresh = 1'b0;
    bit chk_en = 1'b0;
    bit s3_seen = 1'b0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s slot %0d sample %0d: got 0x%0h want 0x%0h", name, e_slot, e_s, act, exp);
        end
    endtask

    function automatic int rate_of(input int r, input int k, input int o, input int f9);
        int v;
        if (r == 0) return 0;
        v = 2 * r + ((k == 15) ? 0 : 2 * (k + o) + f9);
        return (v < 0) ? 0 : (v > 60) ? 60 : v;
    endfunction

    // Amount added/removed this visit; 0 means the rate does not step now.
    function automatic int inc_of(input int rate, input int smp);
        if (rate == 0) return 0;
        if (rate < 48) return (smp % (1 << (11 - rate / 4)) == 0) ? 1 : 0;
        return (rate >= 56) ? 8 : (rate >= 52) ? 4 : 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_evol[i] = 1023;
            m_st[i] = ST_REL;
        end
        m_smp = 0;
        e_evol = 1023;
        e_st = ST_REL;
        e_level = 1023;
        e_valid = 0;
        e_pipe = 0;
        e_fresh = 1'b0;
    endtask

    task automatic model_visit(input int sl, input bit kon, input bit koff, input bit hit);
        int ev, st, r, inc, eff;
        ev = m_evol[sl];
        st = m_st[sl];
        r = (st == ST_ATT) ? ar[sl] : (st == ST_D1) ? d1r[sl] : (st == ST_D2) ? d2r[sl] : rr[sl];
        inc = inc_of(rate_of(r, krs[sl], oct[sl], fns[sl] >> 9), m_smp);
        if (kon) begin
            ev = (ar[sl] == 31) ? 0 : 1023;
            st = (ar[sl] == 31) ? ST_D1 : ST_ATT;
        end else if (koff) st = ST_REL;
        else if (st == ST_ATT && lps[sl] && hit) st = ST_D1;
        else if (st == ST_ATT) begin
            if (inc > 0) begin
                ev = ev - ev / 16 - inc;
                if (ev <= 0) begin
                    ev = 0;
                    st = ST_D1;
                end
            end
        end else begin
            ev = (ev + inc > 1023) ? 1023 : ev + inc;
            if (st == ST_D1 && ev / 32 >= dl[sl]) st = ST_D2;
        end
        m_evol[sl] = ev;
        m_st[sl] = st;
        eff = (eghold[sl] && st == ST_ATT) ? 0 : ev;
        e_evol = ev;
        e_st = st;
        e_level = (eff + 4 * tl[sl] > 1023) ? 1023 : eff + 4 * tl[sl];
        e_valid = 1;
        e_pipe = sl * 4 + int'(kon) * 2 + int'(koff);
        if (sl == 31) m_smp = (m_smp + 1) % 32768;
    endtask

    task automatic drive(input bit ce, input int sl, input bit kon, input bit koff, input bit hit, input int s);
        @(negedge CLK);
        bus.CE = ce;
        bus.PIPE_IN = '{SLOT: 5'(sl), KON: kon, KOFF: koff};
        bus.SCR1 = '{KRS: 4'(krs[sl]), DL: 5'(dl[sl]), RR: 5'(rr[sl]), LPSLNK: lps[sl]};
        bus.SCR2 = '{AR: 5'(ar[sl]), D1R: 5'(d1r[sl]), D2R: 5'(d2r[sl]), EGHOLD: eghold[sl]};
        bus.SCR5 = '{OCT: 4'(oct[sl]), FNS: 10'(fns[sl])};
        bus.TL = 8'(tl[sl]);
        bus.LOOP_HIT = hit;
        e_fresh = ce;
        if (ce) begin
            e_s = s;
            e_slot = sl;
            model_visit(sl, kon, koff, hit);
        end
    endtask

    task automatic do_sample(input int s, input bit quiet);
        bit kon, koff, hit;
        for (int sl = 0; sl < 32; sl++) begin
            if ($urandom_range(7) == 0) drive(1'b0, int'($urandom_range(31)), 1'b1, 1'b1, 1'b1, s);
            kon = 1'b0;
            koff = 1'b0;
            hit = 1'b0;
            if (!quiet && s > 0) begin
                if (sl inside {3, 5, 7, 9, 11}) begin
                    kon = (s == 1);
                    koff = (sl == 9 && s == 1) || (sl == 7 && s == 5);
                    hit = (sl == 11 && s == 11);
                end else begin
                    kon = ($urandom_range(29) == 0);
                    koff = ($urandom_range(29) == 0);
                    hit = ($urandom_range(5) == 0);
                end
            end
            drive(1'b1, sl, kon, koff, hit, s);
        end
    endtask

    task automatic set_slot(input int sl, input int a, input int d1, input int d2, input int r, input int l, input int t, input bit h, input bit lp);
        ar[sl] = a; d1r[sl] = d1; d2r[sl] = d2; rr[sl] = r; dl[sl] = l; tl[sl] = t;
        eghold[sl] = h; lps[sl] = lp; krs[sl] = 15; oct[sl] = 0; fns[sl] = 0;
    endtask

    always @(posedge CLK) begin
        #2;
        if (chk_en) begin
            cmp("valid", int'(bus.VALID), e_valid);
            cmp("pipe_out", int'(bus.PIPE_OUT), e_pipe);
            cmp("evol", int'(bus.EG_OUT.EVOL), e_evol);
            cmp("st", int'(bus.EG_OUT.ST), e_st);
            cmp("level", int'(bus.LEVEL), e_level);
            if (e_fresh) begin
                if (e_s == 0) begin
                    cmp("idle_level", int'(bus.LEVEL), 1023);
                    cmp("idle_st", int'(bus.EG_OUT.ST), ST_REL);
                end
                if (e_slot == 5 && e_s >= 1) cmp("s5_level_hold", int'(bus.LEVEL), 0);
                if (e_slot == 5 && e_s == 1) begin
                    cmp("s5_kon_evol", int'(bus.EG_OUT.EVOL), 0);
                    cmp("s5_kon_st", int'(bus.EG_OUT.ST), ST_D1);
                end
                if (e_slot == 9 && e_s == 1) begin
                    cmp("s9_konkoff_st", int'(bus.EG_OUT.ST), ST_ATT);
                    cmp("s9_konkoff_evol", int'(bus.EG_OUT.EVOL), 1023);
                    cmp("s9_tl_clamp", int'(bus.LEVEL), 1023);
                end
                if (e_slot == 7 && e_s == 6) begin
                    cmp("s7_rel_first", int'(bus.EG_OUT.EVOL), 8);
                    cmp("s7_rel_st", int'(bus.EG_OUT.ST), ST_REL);
                end
                if (e_slot == 7 && e_s == 200) cmp("s7_rel_sat", int'(bus.EG_OUT.EVOL), 1023);
                if (e_slot == 11 && e_s >= 1 && e_s <= 10) begin
                    cmp("s11_hold_level", int'(bus.LEVEL), 0);
                    cmp("s11_attack_st", int'(bus.EG_OUT.ST), ST_ATT);
                end
                if (e_slot == 11 && e_s == 11) begin
                    cmp("s11_loop_st", int'(bus.EG_OUT.ST), ST_D1);
                    cmp("s11_loop_evol", int'(bus.EG_OUT.EVOL), 1023);
                end
                if (e_slot == 3 && e_st == ST_D2 && !s3_seen) begin
                    s3_seen = 1'b1;
                    cmp("s3_dl_evol", int'(bus.EG_OUT.EVOL), 256);
                    cmp("s3_dl_model", e_evol, 256);
                end
            end
        end
    end

    initial begin
        bus.CE = 1'b0;
        bus.PIPE_IN = '0;
        bus.SCR1 = '0;
        bus.SCR2 = '0;
        bus.SCR5 = '0;
        bus.TL = 8'd0;
        bus.LOOP_HIT = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ar[i] = int'($urandom_range(31)); d1r[i] = int'($urandom_range(31));
            d2r[i] = int'($urandom_range(31)); rr[i] = int'($urandom_range(31));
            dl[i] = int'($urandom_range(31)); krs[i] = int'($urandom_range(15));
            oct[i] = int'($urandom_range(15)) - 8; fns[i] = int'($urandom_range(1023));
            tl[i] = int'($urandom_range(63)); eghold[i] = 1'($urandom_range(1));
            lps[i] = 1'($urandom_range(1));
        end
        set_slot(5, 31, 0, 0, 0, 31, 0, 1'b0, 1'b0);
        set_slot(3, 28, 22, 0, 0, 8, 0, 1'b0, 1'b0);
        set_slot(7, 31, 0, 0, 31, 0, 0, 1'b0, 1'b0);
        set_slot(9, 16, 0, 0, 0, 31, 255, 1'b0, 1'b0);
        set_slot(11, 10, 0, 0, 0, 31, 0, 1'b1, 1'b1);
        model_reset();
        e_s = 0;
        e_slot = 0;
        repeat (3) @(posedge CLK);
        #2;
        cmp("rst_valid", int'(bus.VALID), 0);
        cmp("rst_pipe", int'(bus.PIPE_OUT), 0);
        cmp("rst_evol", int'(bus.EG_OUT.EVOL), 1023);
        cmp("rst_st", int'(bus.EG_OUT.ST), ST_REL);
        cmp("rst_level", int'(bus.LEVEL), 1023);
        @(negedge CLK);
        RST_N = 1'b1;
        chk_en = 1'b1;
        for (int s = 0; s < 400; s++) do_sample(s, 1'b0);
        cmp("s3_reached_decay2", int'(s3_seen), 1);
        @(negedge CLK);
        bus.CE = 1'b0;
        chk_en = 1'b0;
        #1 RST_N = 1'b0;
        #1;
        cmp("midrst_valid", int'(bus.VALID), 0);
        cmp("midrst_pipe", int'(bus.PIPE_OUT), 0);
        cmp("midrst_evol", int'(bus.EG_OUT.EVOL), 1023);
        cmp("midrst_st", int'(bus.EG_OUT.ST), ST_REL);
        cmp("midrst_level", int'(bus.LEVEL), 1023);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        chk_en = 1'b1;
        do_sample(0, 1'b1);
        @(posedge CLK);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
